// File: rtl/cmd_flag_scanner.sv
// Command-line token scanner: splits an ASCII byte stream into tokens and
// reports the first terminating flag plus flag/token counts once per line.
module cmd_flag_scanner #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_term_id,
    output logic [CNT_W-1:0] res_flag_cnt,
    output logic [CNT_W-1:0] res_tok_cnt,
    output logic [2:0]       dbg_state
);

    // Handshake: a byte moves on an edge where in_valid && in_ready; the summary
    // moves on an edge where res_valid && res_ready and is held stable until then.

    typedef enum logic [2:0] {
        ST_SEP   = 3'd0,
        ST_DASH1 = 3'd1,
        ST_SHORT = 3'd2,
        ST_LONG  = 3'd3,
        ST_WORD  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_endopt;
    logic [3:0]       r_pos;
    logic             r_match_help;
    logic             r_match_ver;
    logic [7:0]       r_short_char;
    logic             r_short_multi;
    logic [1:0]       r_term;
    logic [CNT_W-1:0] r_flag_cnt;
    logic [CNT_W-1:0] r_tok_cnt;
    logic             r_res_valid;
    logic [1:0]       r_res_term;
    logic [CNT_W-1:0] r_res_flag;
    logic [CNT_W-1:0] r_res_tok;

    state_t           w_nxt_state;
    state_t           w_cls_state;
    logic             w_accept;
    logic             w_sep;
    logic             w_dash;
    logic [3:0]       w_nxt_pos;
    logic             w_nxt_match_help;
    logic             w_nxt_match_ver;
    logic [7:0]       w_nxt_short_char;
    logic             w_nxt_short_multi;
    logic             w_tok_end;
    logic             w_tok_flag;
    logic [1:0]       w_tok_term;
    logic             w_endopt_set;
    logic             w_line_end;
    logic [1:0]       w_term_upd;
    logic [CNT_W-1:0] w_flag_upd;
    logic [CNT_W-1:0] w_tok_upd;

    function automatic logic [7:0] help_char(input logic [3:0] idx);
        case (idx)
            4'd0:    help_char = 8'h68;
            4'd1:    help_char = 8'h65;
            4'd2:    help_char = 8'h6c;
            4'd3:    help_char = 8'h70;
            default: help_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ver_char(input logic [3:0] idx);
        case (idx)
            4'd0:    ver_char = 8'h76;
            4'd1:    ver_char = 8'h65;
            4'd2:    ver_char = 8'h72;
            4'd3:    ver_char = 8'h73;
            4'd4:    ver_char = 8'h69;
            4'd5:    ver_char = 8'h6f;
            4'd6:    ver_char = 8'h6e;
            default: ver_char = 8'h00;
        endcase
    endfunction

    assign w_accept = in_valid && !r_res_valid;
    assign w_sep    = (in_data == 8'h20) || (in_data == 8'h09);
    assign w_dash   = (in_data == 8'h2d);

    // Next-state and per-token match tracking for one accepted byte.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_pos         = r_pos;
        w_nxt_match_help  = r_match_help;
        w_nxt_match_ver   = r_match_ver;
        w_nxt_short_char  = r_short_char;
        w_nxt_short_multi = r_short_multi;
        if (w_accept) begin
            case (r_state)
                ST_SEP: begin
                    if (w_sep)
                        w_nxt_state = ST_SEP;
                    else if (w_dash && !r_endopt)
                        w_nxt_state = ST_DASH1;
                    else
                        w_nxt_state = ST_WORD;
                end
                ST_DASH1: begin
                    if (w_sep) begin
                        w_nxt_state = ST_SEP;
                    end else if (w_dash) begin
                        w_nxt_state      = ST_LONG;
                        w_nxt_pos        = 4'd0;
                        w_nxt_match_help = 1'b1;
                        w_nxt_match_ver  = 1'b1;
                    end else begin
                        w_nxt_state       = ST_SHORT;
                        w_nxt_short_char  = in_data;
                        w_nxt_short_multi = 1'b0;
                    end
                end
                ST_SHORT: begin
                    if (w_sep)
                        w_nxt_state = ST_SEP;
                    else
                        w_nxt_short_multi = 1'b1;
                end
                ST_LONG: begin
                    if (w_sep) begin
                        w_nxt_state = ST_SEP;
                    end else begin
                        w_nxt_match_help = r_match_help && (r_pos < 4'd4) &&
                                           (in_data == help_char(r_pos));
                        w_nxt_match_ver  = r_match_ver && (r_pos < 4'd7) &&
                                           (in_data == ver_char(r_pos));
                        w_nxt_pos        = (r_pos == 4'd15) ? 4'd15 : r_pos + 4'd1;
                    end
                end
                ST_WORD: begin
                    if (w_sep)
                        w_nxt_state = ST_SEP;
                end
                default: w_nxt_state = ST_SEP;
            endcase
        end
    end

    // A separator closes the token held in r_state; a non-separator last byte is
    // appended first, so classification then looks at the post-byte values.
    assign w_cls_state = w_sep ? r_state : w_nxt_state;
    assign w_tok_end   = w_accept && (w_sep ? (r_state != ST_SEP) : in_last);
    assign w_line_end  = w_accept && in_last;

    always_comb begin
        w_tok_flag   = 1'b0;
        w_tok_term   = 2'd0;
        w_endopt_set = 1'b0;
        if (w_tok_end) begin
            case (w_cls_state)
                ST_SHORT: begin
                    w_tok_flag = 1'b1;
                    if (!w_nxt_short_multi && (w_nxt_short_char == 8'h68))
                        w_tok_term = 2'd1;
                    else if (!w_nxt_short_multi && (w_nxt_short_char == 8'h76))
                        w_tok_term = 2'd2;
                end
                ST_LONG: begin
                    if (w_nxt_pos == 4'd0) begin
                        w_endopt_set = 1'b1;
                    end else begin
                        w_tok_flag = 1'b1;
                        if (w_nxt_match_help && (w_nxt_pos == 4'd4))
                            w_tok_term = 2'd1;
                        else if (w_nxt_match_ver && (w_nxt_pos == 4'd7))
                            w_tok_term = 2'd2;
                    end
                end
                default: begin
                    w_tok_flag = 1'b0;
                end
            endcase
        end
    end

    assign w_term_upd = (r_term != 2'd0) ? r_term : w_tok_term;
    assign w_flag_upd = (w_tok_end && w_tok_flag && (r_flag_cnt != CNT_MAX)) ?
                        r_flag_cnt + CNT_ONE : r_flag_cnt;
    assign w_tok_upd  = (w_tok_end && (r_tok_cnt != CNT_MAX)) ?
                        r_tok_cnt + CNT_ONE : r_tok_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_SEP;
            r_endopt      <= 1'b0;
            r_pos         <= 4'd0;
            r_match_help  <= 1'b0;
            r_match_ver   <= 1'b0;
            r_short_char  <= 8'd0;
            r_short_multi <= 1'b0;
            r_term        <= 2'd0;
            r_flag_cnt    <= '0;
            r_tok_cnt     <= '0;
            r_res_valid   <= 1'b0;
            r_res_term    <= 2'd0;
            r_res_flag    <= '0;
            r_res_tok     <= '0;
        end else begin
            if (r_res_valid && res_ready)
                r_res_valid <= 1'b0;
            if (w_line_end) begin
                r_res_valid   <= 1'b1;
                r_res_term    <= w_term_upd;
                r_res_flag    <= w_flag_upd;
                r_res_tok     <= w_tok_upd;
                r_state       <= ST_SEP;
                r_endopt      <= 1'b0;
                r_pos         <= 4'd0;
                r_match_help  <= 1'b0;
                r_match_ver   <= 1'b0;
                r_short_char  <= 8'd0;
                r_short_multi <= 1'b0;
                r_term        <= 2'd0;
                r_flag_cnt    <= '0;
                r_tok_cnt     <= '0;
            end else begin
                r_state       <= w_nxt_state;
                r_endopt      <= r_endopt | w_endopt_set;
                r_pos         <= w_nxt_pos;
                r_match_help  <= w_nxt_match_help;
                r_match_ver   <= w_nxt_match_ver;
                r_short_char  <= w_nxt_short_char;
                r_short_multi <= w_nxt_short_multi;
                r_term        <= w_term_upd;
                r_flag_cnt    <= w_flag_upd;
                r_tok_cnt     <= w_tok_upd;
            end
        end
    end

    assign in_ready     = !r_res_valid;
    assign res_valid    = r_res_valid;
    assign res_term_id  = r_res_term;
    assign res_flag_cnt = r_res_flag;
    assign res_tok_cnt  = r_res_tok;
    assign dbg_state    = r_state;

endmodule
